checkout_lane_arbiter: RTL and testbench

// Shares one price*quantity multiply-accumulate datapath between NUM_LANES checkout keypads.
// - Each lane submits item (price, qty) or TOTAL requests over a req/ack handshake.
// - Round-robin arbitration grants one transaction at a time.
// - Keeps a saturating running sum per lane and returns a result on a one-cycle valid pulse.

---
 rtl/checkout_lane_arbiter.sv | 155 +++++++++++++++
 tb/tb_checkout_lane_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkout_lane_arbiter.sv
// Round-robin arbiter sharing one price*qty multiply-accumulate datapath
// between NUM_LANES checkout keypads, with a saturating running sum per lane.
// Ports:
//   clk, clear            clock; asynchronous active-high reset
//   lane_req/lane_total   per-lane request level and op (0=item, 1=TOTAL)
//   lane_price/lane_qty   packed per-lane operands
//   lane_ack              one-cycle one-hot grant pulse
//   busy                  high whenever the engine is not idle
//   result_*              one-cycle result pulse with lane, sum and op
//   lane_ovf              sticky per-lane saturation flags
//   rd_lane/rd_sum        combinational debug read of one lane's sum
module checkout_lane_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int PRICE_W   = 5,
    parameter int QTY_W     = 3,
    parameter int SUM_W     = 11,
    parameter int MUL_LAT   = 2,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic [NUM_LANES-1:0]         lane_req,
    input  logic [NUM_LANES-1:0]         lane_total,
    input  logic [NUM_LANES*PRICE_W-1:0] lane_price,
    input  logic [NUM_LANES*QTY_W-1:0]   lane_qty,
    output logic [NUM_LANES-1:0]         lane_ack,
    output logic                         busy,
    output logic                         result_valid,
    output logic [LW-1:0]                result_lane,
    output logic [SUM_W-1:0]             result_sum,
    output logic                         result_total,
    output logic [NUM_LANES-1:0]         lane_ovf,
    input  logic [LW-1:0]                rd_lane,
    output logic [SUM_W-1:0]             rd_sum
);

    localparam int PW = PRICE_W + QTY_W;
    localparam int EW = ((PW > SUM_W) ? PW : SUM_W) + 1;
    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    typedef enum logic [1:0] {IDLE, MUL, TOT, DONE} state_t;

    state_t               state;
    state_t               state_n;
    logic [LW-1:0]        rr_ptr;
    logic [LW-1:0]        win;
    logic [PRICE_W-1:0]   price_q;
    logic [QTY_W-1:0]     qty_q;
    logic [CW-1:0]        cnt;
    logic [SUM_W-1:0]     sums [NUM_LANES];

    logic                 found;
    logic [LW-1:0]        win_c;
    logic [LW-1:0]        rr_next;
    logic [PW-1:0]        product;
    logic [EW-1:0]        acc;
    logic                 sat;
    logic [SUM_W-1:0]     item_sum;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        win_c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && lane_req[LW'((int'(rr_ptr) + i) % NUM_LANES)]) begin
                found = 1'b1;
                win_c = LW'((int'(rr_ptr) + i) % NUM_LANES);
            end
        end
    end

    assign rr_next  = (int'(win_c) == NUM_LANES - 1) ? '0 : win_c + 1'b1;
    assign product  = PW'(price_q) * PW'(qty_q);
    assign acc      = EW'(sums[win]) + EW'(product);
    assign sat      = acc > EW'(SUM_MAX);
    assign item_sum = sat ? SUM_MAX : acc[SUM_W-1:0];
    assign rd_sum   = sums[rd_lane];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (found) state_n = lane_total[win_c] ? TOT : MUL;
            MUL:  if (cnt == '0) state_n = DONE;
            TOT:  state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            rr_ptr       <= '0;
            win          <= '0;
            price_q      <= '0;
            qty_q        <= '0;
            cnt          <= '0;
            lane_ack     <= '0;
            lane_ovf     <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_lane  <= '0;
            result_sum   <= '0;
            result_total <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) sums[i] <= '0;
        end else begin
            lane_ack     <= '0;
            result_valid <= 1'b0;
            busy         <= (state_n != IDLE);
            unique case (state)
                IDLE: begin
                    if (found) begin
                        lane_ack[win_c] <= 1'b1;
                        win             <= win_c;
                        rr_ptr          <= rr_next;
                        price_q <= lane_price[int'(win_c)*PRICE_W +: PRICE_W];
                        qty_q   <= lane_qty[int'(win_c)*QTY_W +: QTY_W];
                        // Counts the remaining MUL cycles after the first.
                        cnt     <= CW'(MUL_LAT - 1);
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        sums[win]    <= item_sum;
                        if (sat) lane_ovf[win] <= 1'b1;
                        result_valid <= 1'b1;
                        result_lane  <= win;
                        result_sum   <= item_sum;
                        result_total <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TOT: begin
                    result_valid  <= 1'b1;
                    result_lane   <= win;
                    result_sum    <= sums[win];
                    result_total  <= 1'b1;
                    sums[win]     <= '0;
                    lane_ovf[win] <= 1'b0;
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_checkout_lane_arbiter.sv
// Scoreboard bench for checkout_lane_arbiter: directed scenarios plus
// randomized lane traffic against a per-lane arithmetic reference model.
module tb_checkout_lane_arbiter;

    localparam int N    = 4;
    localparam int PW   = 5;
    localparam int QW   = 3;
    localparam int SW   = 11;
    localparam int ML   = 2;
    localparam int LW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            clear;
    logic [N-1:0]    lane_req;
    logic [N-1:0]    lane_total;
    logic [N*PW-1:0] lane_price;
    logic [N*QW-1:0] lane_qty;
    logic [N-1:0]    lane_ack;
    logic            busy;
    logic            result_valid;
    logic [LW-1:0]   result_lane;
    logic [SW-1:0]   result_sum;
    logic            result_total;
    logic [N-1:0]    lane_ovf;
    logic [LW-1:0]   rd_lane;
    logic [SW-1:0]   rd_sum;

    checkout_lane_arbiter #(
        .NUM_LANES(N), .PRICE_W(PW), .QTY_W(QW), .SUM_W(SW), .MUL_LAT(ML)
    ) dut (
        .clk(clk), .clear(clear),
        .lane_req(lane_req), .lane_total(lane_total),
        .lane_price(lane_price), .lane_qty(lane_qty),
        .lane_ack(lane_ack), .busy(busy),
        .result_valid(result_valid), .result_lane(result_lane),
        .result_sum(result_sum), .result_total(result_total),
        .lane_ovf(lane_ovf), .rd_lane(rd_lane), .rd_sum(rd_sum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        bit tot;
        bit ovf;
        int post;
    } exp_t;

    exp_t sb [N][$];
    int   msum [N];
    bit   movf [N];
    int   checks   = 0;
    int   failures = 0;
    int   nres     = 0;
    int   res_cyc  = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: sum grows by price*qty, clamped at SMAX; TOTAL reads then zeroes.
    task automatic issue(input int l, input bit t, input int p, input int q);
        exp_t e;
        if (t) begin
            e.sum = msum[l]; e.tot = 1'b1; e.ovf = 1'b0; e.post = 0;
            msum[l] = 0;
            movf[l] = 1'b0;
        end else begin
            msum[l] = msum[l] + p * q;
            if (msum[l] > SMAX) begin
                msum[l] = SMAX;
                movf[l] = 1'b1;
            end
            e.sum = msum[l]; e.tot = 1'b0; e.ovf = movf[l]; e.post = msum[l];
        end
        sb[l].push_back(e);
    endtask

    task automatic request(input int l, input bit t, input int p, input int q);
        lane_total[l]          = t;
        lane_price[l*PW +: PW] = PW'(p);
        lane_qty[l*QW +: QW]   = QW'(q);
        lane_req[l]            = 1'b1;
        issue(l, t, p, q);
    endtask

    task automatic flush_model();
        for (int l = 0; l < N; l++) begin
            sb[l].delete();
            msum[l] = 0;
            movf[l] = 1'b0;
        end
    endtask

    task automatic wait_any(output int w, output int c);
        int n = 0;
        w = -1;
        do begin
            @(negedge clk); #2;
            n++;
        end while (lane_ack == '0 && n < 60);
        for (int i = 0; i < N; i++) if (lane_ack[i]) w = i;
        check("ack_onehot", $countones(lane_ack), 1);
        c = cyc;
    endtask

    task automatic wait_ack(input int l, output int c);
        int w;
        wait_any(w, c);
        check("ack_lane", w, l);
    endtask

    task automatic wait_results(input int n0, input int k);
        int n = 0;
        while (nres < n0 + k && n < 80) begin
            @(negedge clk); #2;
            n++;
        end
        check("results_seen", nres - n0, k);
    endtask

    task automatic txn(input int l, input bit t, input int p, input int q);
        int a;
        int n0;
        n0      = nres;
        rd_lane = LW'(l);
        request(l, t, p, q);
        wait_ack(l, a);
        lane_req[l] = 1'b0;
        wait_results(n0, 1);
        check("latency", res_cyc - a, t ? 1 : ML);
    endtask

    // Monitor: pops the lane's expected result whenever the DUT reports one.
    initial begin : monitor
        int   l;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clear && result_valid) begin
                l = int'(result_lane);
                nres++;
                res_cyc = cyc;
                if (sb[l].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result lane=%0d sum=%0d", l, result_sum);
                end else begin
                    e = sb[l].pop_front();
                    check("result_sum", int'(result_sum), e.sum);
                    check("result_total", int'(result_total), int'(e.tot));
                    check("lane_ovf", int'(lane_ovf[l]), int'(e.ovf));
                    if (int'(rd_lane) == l)
                        check("rd_sum_after", int'(rd_sum), e.post);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int           a;
        int           a2;
        int           w;
        int           c;
        int           prev;
        int           n0;
        int           ew;
        int           ptr_m;
        int           cycles;
        int           ops_left [N];
        int           age [N];
        logic [N-1:0] snap;
        bit           t;

        clear      = 1'b1;
        lane_req   = '0;
        lane_total = '0;
        lane_price = '0;
        lane_qty   = '0;
        rd_lane    = '0;
        flush_model();
        repeat (2) @(negedge clk);
        #2 clear = 1'b0;

        check("rst_ack", int'(lane_ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_lane", int'(result_lane), 0);
        check("rst_sum", int'(result_sum), 0);
        check("rst_total", int'(result_total), 0);
        check("rst_ovf", int'(lane_ovf), 0);
        for (int l = 0; l < N; l++) begin
            rd_lane = LW'(l);
            #1 check("rst_rd_sum", int'(rd_sum), 0);
        end

        txn(1, 1'b0, 12, 3);
        txn(1, 1'b0, 20, 5);
        txn(1, 1'b1, 0, 0);
        check("lane1_total_sum", int'(result_sum), 136);

        for (int k = 0; k < 10; k++) txn(3, 1'b0, 31, 7);
        check("lane3_sat_sum", int'(result_sum), 2047);
        check("lane3_ovf_set", int'(lane_ovf[3]), 1);
        txn(3, 1'b1, 0, 0);
        check("lane3_total_sum", int'(result_sum), 2047);
        check("lane3_ovf_clr", int'(lane_ovf[3]), 0);

        // Lane2 keeps req high through its first transaction.
        n0      = nres;
        rd_lane = LW'(2);
        request(2, 1'b0, 9, 4);
        issue(2, 1'b0, 9, 4);
        wait_ack(2, a);
        wait_ack(2, a2);
        lane_req[2] = 1'b0;
        check("regrant_gap", a2 - a, ML + 2);
        wait_results(n0, 2);
        check("lane2_double", int'(rd_sum), 72);

        // Clear in the middle of a lane0 multiply.
        rd_lane = '0;
        request(0, 1'b0, 5, 2);
        wait_ack(0, a);
        lane_req[0] = 1'b0;
        @(negedge clk); #2;
        check("mid_mul_busy", int'(busy), 1);
        clear    = 1'b1;
        lane_req = '0;
        flush_model();
        @(negedge clk); #2;
        clear = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("clr_busy", int'(busy), 0);
        check("clr_ovf", int'(lane_ovf), 0);
        for (int l = 0; l < N; l++) begin
            rd_lane = LW'(l);
            #1 check("clr_rd_sum", int'(rd_sum), 0);
        end

        // All lanes request together; lane0 stays up for a second grant.
        n0      = nres;
        rd_lane = '0;
        prev    = 0;
        for (int l = 0; l < N; l++) request(l, 1'b0, 1, 1);
        for (int k = 0; k < 5; k++) begin
            wait_any(w, c);
            check("grant_order", w, k % N);
            if (k > 0) check("ack_spacing_ok", int'(c - prev >= ML + 2), 1);
            prev = c;
            if (k == 0) issue(0, 1'b0, 1, 1);
            else if (w >= 0) lane_req[w] = 1'b0;
        end
        wait_results(n0, 5);

        // Randomized traffic from a fresh reset.
        clear    = 1'b1;
        lane_req = '0;
        flush_model();
        @(negedge clk); #2;
        clear  = 1'b0;
        ptr_m  = 0;
        cycles = 0;
        for (int l = 0; l < N; l++) begin
            ops_left[l] = 15;
            age[l]      = 0;
        end
        while (cycles < 4000 &&
               (ops_left[0] + ops_left[1] + ops_left[2] + ops_left[3] > 0 ||
                lane_req != '0)) begin
            @(negedge clk); #3;
            cycles++;
            snap = lane_req;
            if (lane_ack != '0) begin
                w = -1;
                for (int i = 0; i < N; i++) if (lane_ack[i]) w = i;
                ew = -1;
                for (int i = 0; i < N; i++)
                    if (ew < 0 && snap[(ptr_m + i) % N]) ew = (ptr_m + i) % N;
                check("rr_winner", w, ew);
                if (w >= 0) begin
                    ptr_m       = (w + 1) % N;
                    lane_req[w] = 1'b0;
                end
            end
            for (int l = 0; l < N; l++) begin
                if (lane_req[l]) begin
                    age[l]++;
                    if (age[l] == 80) begin
                        checks++;
                        failures++;
                        $display("FAIL req_wait lane=%0d waited %0d cycles", l, age[l]);
                        lane_req[l] = 1'b0;
                    end
                end else if (ops_left[l] > 0 && $urandom_range(3) == 0) begin
                    t = ($urandom_range(4) == 0);
                    request(l, t, int'($urandom_range(31)), int'($urandom_range(7)));
                    ops_left[l]--;
                    age[l] = 0;
                end
            end
            rd_lane = LW'($urandom_range(N - 1));
        end

        for (int n = 0; n < 60; n++) begin
            if (sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size() == 0)
                break;
            @(negedge clk); #3;
        end
        for (int l = 0; l < N; l++) check("sb_drained", sb[l].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
